asrv32_clint: RTL and testbench

Parametrised core-local interruptor (CLINT) serving up to eight asrv32 harts from one memory-mapped slave port. It owns the shared 64-bit `mtime` counter with a prescaler, one 64-bit `mtimecmp` and one `msip` bit per hart, and drives each hart's timer and software interrupt lines plus a broadcast `mtime` value. It sits on the data bus beside RAM; its outputs feed the core's interrupt and timer inputs.

---
 rtl/asrv32_pkg.sv | 35 +++
 rtl/asrv32_clint_timer.sv | 41 ++++
 rtl/asrv32_clint.sv | 132 +++++++++++++
 tb/tb_asrv32_clint.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/asrv32_pkg.sv
// Shared asrv32 constants: CLINT address map, hart limit and the register
// select type used by the CLINT decoder.
package asrv32_pkg;

  localparam logic [15:0] CLINT_MSIP_BASE     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI      = 16'hBFFC;
  localparam int unsigned CLINT_MAX_HARTS     = 8;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_MSIP,
    REG_MTIMECMP,
    REG_MTIME
  } clint_reg_e;

  typedef struct packed {
    clint_reg_e sel;
    logic [2:0] hart;
    logic       hi;
  } clint_decode_t;

  // Byte-lane merge used by every writable 32-bit word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = mask[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/asrv32_clint_timer.sv
// Shared mtime counter: prescaler, 64-bit increment and bus write override.
module asrv32_clint_timer
  import asrv32_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wmask,
  output logic [63:0] o_mtime
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] prescale_cnt;
  logic        tick;

  assign tick = (prescale_cnt == PRE_LAST);

  // A bus write to either half replaces the increment for that cycle; the
  // prescaler is never disturbed so the tick cadence stays fixed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prescale_cnt <= '0;
      o_mtime      <= '0;
    end else begin
      prescale_cnt <= tick ? '0 : prescale_cnt + 16'd1;
      if (i_wr_lo) begin
        o_mtime[31:0] <= merge_bytes(o_mtime[31:0], i_wdata, i_wmask);
      end else if (i_wr_hi) begin
        o_mtime[63:32] <= merge_bytes(o_mtime[63:32], i_wdata, i_wmask);
      end else if (tick) begin
        o_mtime <= o_mtime + 64'd1;
      end
    end
  end

endmodule

// File: rtl/asrv32_clint.sv
// Core-local interruptor: shared mtime, per-hart mtimecmp/msip and a
// single-cycle memory-mapped slave port.
module asrv32_clint
  import asrv32_pkg::*;
#(
  parameter int unsigned NUM_HARTS = 1,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic                 i_we,
  input  logic [15:0]          i_addr,
  input  logic [31:0]          i_wdata,
  input  logic [3:0]           i_wmask,
  output logic                 o_ack,
  output logic [31:0]          o_rdata,
  output logic                 o_err,
  output logic [NUM_HARTS-1:0] o_timer_irq,
  output logic [NUM_HARTS-1:0] o_software_irq,
  output logic [63:0]          o_mtime
);

  logic [63:0]          mtime;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;
  clint_decode_t        dec;
  logic [15:0]          word_addr;
  logic [15:0]          msip_off;
  logic [15:0]          cmp_off;
  logic [31:0]          rdata_nxt;
  logic                 wr_en;
  logic                 wr_mtime_lo;
  logic                 wr_mtime_hi;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^i_addr[1:0];
  assign word_addr        = {i_addr[15:2], 2'b00};
  // Offsets wrap below their base, so a single unsigned compare bounds each window.
  assign msip_off         = word_addr - CLINT_MSIP_BASE;
  assign cmp_off          = word_addr - CLINT_MTIMECMP_BASE;

  always_comb begin
    dec = '{sel: REG_NONE, hart: 3'd0, hi: 1'b0};
    if (msip_off < 16'(4 * NUM_HARTS)) begin
      dec.sel  = REG_MSIP;
      dec.hart = msip_off[4:2];
    end else if (cmp_off < 16'(8 * NUM_HARTS)) begin
      dec.sel  = REG_MTIMECMP;
      dec.hart = cmp_off[5:3];
      dec.hi   = cmp_off[2];
    end else if (word_addr == CLINT_MTIME_LO) begin
      dec.sel = REG_MTIME;
    end else if (word_addr == CLINT_MTIME_HI) begin
      dec.sel = REG_MTIME;
      dec.hi  = 1'b1;
    end
  end

  assign wr_en       = i_req & i_we;
  assign wr_mtime_lo = wr_en && (dec.sel == REG_MTIME) && !dec.hi && (|i_wmask);
  assign wr_mtime_hi = wr_en && (dec.sel == REG_MTIME) &&  dec.hi && (|i_wmask);

  asrv32_clint_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr_lo (wr_mtime_lo),
    .i_wr_hi (wr_mtime_hi),
    .i_wdata (i_wdata),
    .i_wmask (i_wmask),
    .o_mtime (mtime)
  );

  always_comb begin
    rdata_nxt = '0;
    case (dec.sel)
      REG_MSIP: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (dec.hart == 3'(h)) rdata_nxt = {31'b0, msip[h]};
        end
      end
      REG_MTIMECMP: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (dec.hart == 3'(h)) rdata_nxt = dec.hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
        end
      end
      REG_MTIME: rdata_nxt = dec.hi ? mtime[63:32] : mtime[31:0];
      default:   rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      msip        <= '0;
      o_timer_irq <= '0;
      for (int h = 0; h < NUM_HARTS; h++) mtimecmp[h] <= '1;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        o_timer_irq[h] <= (mtime >= mtimecmp[h]);
        if (wr_en && (dec.hart == 3'(h))) begin
          if ((dec.sel == REG_MSIP) && i_wmask[0]) msip[h] <= i_wdata[0];
          if (dec.sel == REG_MTIMECMP) begin
            if (dec.hi) begin
              mtimecmp[h][63:32] <= merge_bytes(mtimecmp[h][63:32], i_wdata, i_wmask);
            end else begin
              mtimecmp[h][31:0]  <= merge_bytes(mtimecmp[h][31:0], i_wdata, i_wmask);
            end
          end
        end
      end
    end
  end

  // Read data is captured before any same-cycle tick or write lands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ack   <= 1'b0;
      o_err   <= 1'b0;
      o_rdata <= '0;
    end else begin
      o_ack   <= i_req;
      o_err   <= i_req && (dec.sel == REG_NONE);
      o_rdata <= (i_req && !i_we) ? rdata_nxt : '0;
    end
  end

  assign o_software_irq = msip;
  assign o_mtime        = mtime;

endmodule

// File: tb/tb_asrv32_clint.sv
// Bench for asrv32_clint: two instances (2 harts/prescale 1, 1 hart/prescale 4)
// share one stimulus stream and are compared every cycle against a reference model.
module tb_asrv32_clint;

  localparam int NH_A = 2;
  localparam int PS_A = 1;
  localparam int NH_B = 1;
  localparam int PS_B = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;

  logic            ack_a, err_a, ack_b, err_b;
  logic [31:0]     rdata_a, rdata_b;
  logic [NH_A-1:0] tirq_a, sirq_a;
  logic [NH_B-1:0] tirq_b, sirq_b;
  logic [63:0]     mtime_a, mtime_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  asrv32_clint #(.NUM_HARTS(NH_A), .PRESCALE(PS_A)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_wmask(wmask), .o_ack(ack_a), .o_rdata(rdata_a),
    .o_err(err_a), .o_timer_irq(tirq_a), .o_software_irq(sirq_a), .o_mtime(mtime_a)
  );

  asrv32_clint #(.NUM_HARTS(NH_B), .PRESCALE(PS_B)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_wmask(wmask), .o_ack(ack_b), .o_rdata(rdata_b),
    .o_err(err_b), .o_timer_irq(tirq_b), .o_software_irq(sirq_b), .o_mtime(mtime_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_mt   [2];
  int          m_pre  [2];
  logic [63:0] m_cmp  [2][8];
  logic [7:0]  m_msip [2];
  logic        e_ack  [2];
  logic        e_err  [2];
  logic        e_rchk [2];
  logic [31:0] e_rdata[2];
  logic [7:0]  e_tirq [2];

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = m[b] ? n[b*8 +: 8] : o[b*8 +: 8];
    return r;
  endfunction

  task automatic model_step(input int d, input int nh, input int ps);
    logic [15:0] w;
    logic [31:0] rd;
    logic [63:0] mt_new;
    logic        hit, tick, mt_wr;
    int          h;
    if (rst) begin
      m_mt[d] = 64'd0; m_pre[d] = 0; m_msip[d] = 8'd0;
      for (int k = 0; k < 8; k++) m_cmp[d][k] = '1;
      e_ack[d] = 1'b0; e_err[d] = 1'b0; e_rdata[d] = 32'd0; e_rchk[d] = 1'b1;
      e_tirq[d] = 8'd0;
      return;
    end
    for (int k = 0; k < 8; k++) e_tirq[d][k] = (k < nh) && (m_mt[d] >= m_cmp[d][k]);
    w = {addr[15:2], 2'b00};
    hit = 1'b0; rd = 32'd0; mt_wr = 1'b0; mt_new = m_mt[d];
    if (req) begin
      if (int'(w) < 4 * nh) begin
        hit = 1'b1; h = int'(w) / 4;
        rd = {31'b0, m_msip[d][h]};
        if (we && wmask[0]) m_msip[d][h] = wdata[0];
      end else if (int'(w) >= 'h4000 && int'(w) < 'h4000 + 8 * nh) begin
        hit = 1'b1; h = (int'(w) - 'h4000) / 8;
        if (w[2]) begin
          rd = m_cmp[d][h][63:32];
          if (we) m_cmp[d][h][63:32] = lanes(m_cmp[d][h][63:32], wdata, wmask);
        end else begin
          rd = m_cmp[d][h][31:0];
          if (we) m_cmp[d][h][31:0] = lanes(m_cmp[d][h][31:0], wdata, wmask);
        end
      end else if (w == 16'hBFF8) begin
        hit = 1'b1; rd = m_mt[d][31:0];
        mt_wr = we && (wmask != 4'd0);
        mt_new[31:0] = lanes(m_mt[d][31:0], wdata, wmask);
      end else if (w == 16'hBFFC) begin
        hit = 1'b1; rd = m_mt[d][63:32];
        mt_wr = we && (wmask != 4'd0);
        mt_new[63:32] = lanes(m_mt[d][63:32], wdata, wmask);
      end
    end
    e_ack[d]   = req;
    e_err[d]   = req && !hit;
    e_rchk[d]  = !(req && we);
    e_rdata[d] = (req && !we) ? rd : 32'd0;
    tick = (m_pre[d] == ps - 1);
    m_pre[d] = tick ? 0 : m_pre[d] + 1;
    if (mt_wr) m_mt[d] = mt_new;
    else if (tick) m_mt[d] = m_mt[d] + 64'd1;
  endtask

  always @(posedge clk) begin
    model_step(0, NH_A, PS_A);
    model_step(1, NH_B, PS_B);
    #1;
    check("a_mtime", mtime_a, m_mt[0]);
    check("a_ack",   ack_a,   e_ack[0]);
    check("a_err",   err_a,   e_err[0]);
    if (e_rchk[0]) check("a_rdata", rdata_a, e_rdata[0]);
    check("a_tirq",  tirq_a,  e_tirq[0][NH_A-1:0]);
    check("a_sirq",  sirq_a,  m_msip[0][NH_A-1:0]);
    check("b_mtime", mtime_b, m_mt[1]);
    check("b_ack",   ack_b,   e_ack[1]);
    check("b_err",   err_b,   e_err[1]);
    if (e_rchk[1]) check("b_rdata", rdata_b, e_rdata[1]);
    check("b_tirq",  tirq_b,  e_tirq[1][NH_B-1:0]);
    check("b_sirq",  sirq_b,  m_msip[1][NH_B-1:0]);
  end

  // ---------------- directed + random stimulus ----------------
  logic        r_ack, r_err;
  logic [31:0] r_rdata;
  logic [63:0] prev;
  logic        found;

  // Called just after a falling edge; returns at the next falling edge with
  // dut_a's response captured.
  task automatic bus(input logic w, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] m);
    req = 1'b1; we = w; addr = a; wdata = d; wmask = m;
    @(negedge clk);
    r_ack = ack_a; r_err = err_a; r_rdata = rdata_a;
    req = 1'b0; we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wmask = '0;
    repeat (3) @(negedge clk);
    check("rst_ack",   ack_a,   0);
    check("rst_mtime", mtime_a, 0);
    check("rst_tirq",  tirq_a,  0);
    check("rst_sirq",  sirq_a,  0);

    rst = 1'b0;
    bus(1'b0, 16'hBFF8, 32'd0, 4'd0);
    check("t1_ack", r_ack, 1);
    check("t1_rdata", r_rdata, 0);
    check("t1_first_tick", mtime_a, 1);
    bus(1'b0, 16'h4000, 32'd0, 4'd0);
    check("t1_cmp_lo", r_rdata, 32'hFFFF_FFFF);
    bus(1'b0, 16'h4004, 32'd0, 4'd0);
    check("t1_cmp_hi", r_rdata, 32'hFFFF_FFFF);

    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF);
    check("t2_written", mtime_a, 64'h0000_0000_FFFF_FFFE);
    repeat (2) @(negedge clk);
    check("t2_carry", mtime_a, 64'h0000_0001_0000_0000);
    bus(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
    bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF);
    check("t2_allones", mtime_a, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("t2_wrap", mtime_a, 64'd0);

    bus(1'b1, 16'h400C, 32'd0, 4'hF);
    bus(1'b1, 16'h4008, 32'd20, 4'hF);
    bus(1'b1, 16'hBFFC, 32'd0, 4'hF);
    bus(1'b1, 16'hBFF8, 32'd18, 4'hF);
    check("t3_mt18", mtime_a, 18);
    check("t3_irq18", tirq_a, 2'b00);
    @(negedge clk);
    check("t3_irq19", tirq_a, 2'b00);
    @(negedge clk);
    check("t3_mt20", mtime_a, 20);
    check("t3_irq20", tirq_a, 2'b00);
    @(negedge clk);
    check("t3_irq_rise", tirq_a, 2'b10);

    bus(1'b1, 16'h0004, 32'h1, 4'b0001);
    check("t4_msip_set", sirq_a, 2'b10);
    bus(1'b1, 16'h0004, 32'hFFFF_FFFE, 4'hF);
    check("t4_msip_clr", sirq_a, 2'b00);
    bus(1'b1, 16'h0004, 32'h1, 4'b0000);
    check("t4_mask0", sirq_a, 2'b00);

    prev = mtime_b; found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (mtime_b != prev) found = 1'b1;
    end
    check("t5_tick_seen", found, 1);
    prev = mtime_b;
    repeat (3) begin
      @(negedge clk);
      check("t5_hold", mtime_b, prev);
    end
    bus(1'b1, 16'hBFF8, 32'h0000_1234, 4'hF);
    check("t5_written", mtime_b[31:0], 32'h1234);
    repeat (3) begin
      @(negedge clk);
      check("t5_no_extra", mtime_b[31:0], 32'h1234);
    end
    @(negedge clk);
    check("t5_next_tick", mtime_b[31:0], 32'h1235);

    bus(1'b0, 16'h0008, 32'd0, 4'd0);
    check("t6_rd_ack", r_ack, 1);
    check("t6_rd_err", r_err, 1);
    check("t6_rd_data", r_rdata, 0);
    bus(1'b1, 16'h1000, 32'hFFFF_FFFF, 4'hF);
    check("t6_wr_ack", r_ack, 1);
    check("t6_wr_err", r_err, 1);
    check("t6_wr_sirq", sirq_a, 2'b00);
    bus(1'b0, 16'h400C, 32'd0, 4'd0);
    check("t6_b2b_ack1", r_ack, 1);
    check("t6_b2b_cmp1_hi", r_rdata, 0);
    bus(1'b0, 16'h4008, 32'd0, 4'd0);
    check("t6_b2b_ack2", r_ack, 1);
    check("t6_b2b_cmp1_lo", r_rdata, 20);
    @(negedge clk);
    check("t6_ack_idle", ack_a, 0);

    rst = 1'b1; req = 1'b1; we = 1'b1; addr = 16'h0004; wdata = 32'h1; wmask = 4'h1;
    @(negedge clk);
    check("rst_mid_ack", ack_a, 0);
    check("rst_mid_sirq", sirq_a, 2'b00);
    rst = 1'b0; req = 1'b0; we = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      req = ($urandom_range(0, 3) != 0);
      we  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       addr = 16'(4 * $urandom_range(0, 2));
        1, 2:    addr = 16'h4000 + 16'(4 * $urandom_range(0, 5));
        3, 4:    addr = ($urandom_range(0, 1) != 0) ? 16'hBFF8 : 16'hBFFC;
        default: addr = 16'($urandom);
      endcase
      addr[1:0] = 2'($urandom);
      wdata = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
      wmask = 4'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; req = 1'b0; we = 1'b0;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
